regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Parametrised successor to the single-port 8-bit x4 register file.
- One write port, two independent read ports, and asynchronous clear.
- Write-to-read bypass in the same cycle.
- Per-register busy scoreboard: a producer marks a register pending, and the matching write clears it.
- Sits between the decode/issue logic and the ALU datapath of the small CPU.

Parameters:
- WIDTH, 8, data width of each register in bits.
- AW, 2, address width; DEPTH = 2**AW registers.

Ports:
- ck  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable.
- inaddr  input  AW  write address.
- din  input  WIDTH  write data.
- set_busy  input  1  mark register set_addr as pending.
- set_addr  input  AW  register to mark pending.
- outaddr_a  input  AW  read port A address.
- dout_a  output  WIDTH  read port A data.
- busy_a  output  1  register at outaddr_a pending.
- outaddr_b  input  AW  read port B address.
- dout_b  output  WIDTH  read port B data.
- busy_b  output  1  register at outaddr_b pending.
- busy_vec  output  DEPTH  full scoreboard; bit i = register i pending.

Behaviour:
- Storage: DEPTH x WIDTH flops, plus DEPTH busy flops.
- Reset: rst_n=0 asynchronously forces all registers and all busy bits to 0, regardless of ck.
  - While reset is held: dout_a=0, dout_b=0, busy_a=0, busy_b=0, busy_vec=0.
  - Writes and set_busy are ignored.
  - Reset asserted mid-write discards that write.
- Write: on a rising ck with we=1, mem[inaddr] <= din and busy[inaddr] <= 0.
- Read: combinational (zero latency).
  - dout_x = mem[outaddr_x]; busy_x = busy[outaddr_x].
- Bypass: if we=1 and outaddr_x == inaddr in the same cycle, then dout_x = din and busy_x = 0 before the edge (write-first forwarding).
  - Applies to both ports independently.
  - Both ports may bypass at once.
- Scoreboard: on a rising ck with set_busy=1, busy[set_addr] <= 1.
  - set_busy with set_addr == inaddr and we=1 in the same cycle: data is written AND busy ends at 1 (new producer wins over completing producer).
  - Bypass for busy_x is overridden in this case: busy_x reflects the pre-edge value, not 0.
  - set_busy on an already-busy register: stays 1, no error.
  - Write to a non-busy register: allowed, busy stays 0.
- Address wrap: addresses are exactly AW bits; no out-of-range case exists.
- No handshaking stalls; the block never backpressures.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired: reads return 0 and busy 0.
  - Writes to address 0 are dropped.
  - set_busy to address 0 is dropped.
  - Bypass never applies to address 0.
  - busy_vec[0] is constant 0.
- Undefined: register 0 behaves like every other register.

Test Plan:
- Reset: hold rst_n=0 with we=1, din=8'hFF for 2 cycles, then release -> dout_a=dout_b=0, busy_vec=4'b0000, all registers read 0.
- Fill and dual read: write 8'h01, 8'h02, 8'h03, 8'h04 to addresses 0..3; then outaddr_a=1, outaddr_b=3 -> dout_a=8'h02, dout_b=8'h04; swap addresses -> values swap with no added latency.
- Bypass: mem[2]=8'h03; drive we=1, inaddr=2, din=8'hA5, outaddr_a=outaddr_b=2 -> both ports show 8'hA5 before the edge, and mem[2]=8'hA5 after it.
- Scoreboard: set_busy at address 1 -> busy_vec=4'b0010, busy_a=1 with outaddr_a=1; next cycle write address 1 with din=8'h77 -> busy_a=0 during the write cycle (bypass), busy_vec=4'b0000 after.
- Simultaneous set and write: we=1, inaddr=3, din=8'h5A, set_busy=1, set_addr=3 -> mem[3]=8'h5A and busy_vec[3]=1 after the edge.
- Async reset mid-run: registers hold data with busy_vec=4'b1010; pulse rst_n low between clock edges -> all outputs 0 immediately, without waiting for ck.
- With REGFILE_ZERO_REG_EN defined, the same bench additionally checks: write 8'hFF to address 0 -> dout_a=0 at outaddr_a=0.

Source files
------------

// File: rtl/regfile_2r1w.sv
// Parametrised 2-read/1-write register file with write-first bypass and a per-register busy scoreboard.
// Optional build macro REGFILE_ZERO_REG_EN hardwires register 0 to zero and never busy.
module regfile_2r1w #(
  parameter  int WIDTH = 8,
  parameter  int AW    = 2,
  localparam int DEPTH = 1 << AW
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    inaddr,
  input  logic [WIDTH-1:0] din,
  input  logic             set_busy,
  input  logic [AW-1:0]    set_addr,
  input  logic [AW-1:0]    outaddr_a,
  output logic [WIDTH-1:0] dout_a,
  output logic             busy_a,
  input  logic [AW-1:0]    outaddr_b,
  output logic [WIDTH-1:0] dout_b,
  output logic             busy_b,
  output logic [DEPTH-1:0] busy_vec
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy_q;

  logic wr_en;
  logic set_en;
  logic hold_busy;

  // Gating with rst_n keeps the bypass path from leaking din while reset is held.
  assign wr_en     = we && rst_n && !(ZERO_REG && inaddr == '0);
  assign set_en    = set_busy && rst_n && !(ZERO_REG && set_addr == '0);
  // A new producer claiming the register being written wins over the completing one.
  assign hold_busy = set_en && (set_addr == inaddr);

  // NOTE: the data array is reset too, since reset must leave every register reading zero;
  // non-blocking assignments keep all state updates ordered against the same clock edge.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[inaddr] <= din;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (set_en && set_addr == AW'(i)) busy_q[i] <= 1'b1;
        else if (wr_en && inaddr == AW'(i)) busy_q[i] <= 1'b0;
      end
    end
  end

  assign busy_vec = busy_q & ~DEPTH'(ZERO_REG);

  // NOTE: every output gets its default first so no path through this block infers a latch.
  always_comb begin
    dout_a = mem[outaddr_a];
    busy_a = busy_q[outaddr_a];
    dout_b = mem[outaddr_b];
    busy_b = busy_q[outaddr_b];
    if (wr_en && outaddr_a == inaddr) begin
      dout_a = din;
      if (!hold_busy) busy_a = 1'b0;
    end
    if (wr_en && outaddr_b == inaddr) begin
      dout_b = din;
      if (!hold_busy) busy_b = 1'b0;
    end
    if (ZERO_REG && outaddr_a == '0) begin
      dout_a = '0;
      busy_a = 1'b0;
    end
    if (ZERO_REG && outaddr_b == '0) begin
      dout_b = '0;
      busy_b = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed scenarios plus randomized traffic against an array-based model.
// Define REGFILE_ZERO_REG_EN for both bench and RTL to exercise the hardwired-zero register.
module tb_regfile_2r1w;
  localparam int WIDTH = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic             ck = 1'b0;
  logic             rst_n;
  logic             we;
  logic [AW-1:0]    inaddr;
  logic [WIDTH-1:0] din;
  logic             set_busy;
  logic [AW-1:0]    set_addr;
  logic [AW-1:0]    outaddr_a;
  logic [WIDTH-1:0] dout_a;
  logic             busy_a;
  logic [AW-1:0]    outaddr_b;
  logic [WIDTH-1:0] dout_b;
  logic             busy_b;
  logic [DEPTH-1:0] busy_vec;

  int tests = 0;
  int fails = 0;

  int ref_mem  [DEPTH];
  int ref_busy [DEPTH];

  regfile_2r1w #(.WIDTH(WIDTH), .AW(AW)) dut (
    .ck(ck), .rst_n(rst_n), .we(we), .inaddr(inaddr), .din(din),
    .set_busy(set_busy), .set_addr(set_addr),
    .outaddr_a(outaddr_a), .dout_a(dout_a), .busy_a(busy_a),
    .outaddr_b(outaddr_b), .dout_b(dout_b), .busy_b(busy_b),
    .busy_vec(busy_vec)
  );

  always #5 ck = ~ck;

  function automatic bit write_live();
    return rst_n && we && !(ZERO && inaddr == 0);
  endfunction

  function automatic logic [WIDTH-1:0] exp_dout(input int a);
    if (!rst_n || (ZERO && a == 0)) return '0;
    if (write_live() && a == int'(inaddr)) return din;
    return ref_mem[a][WIDTH-1:0];
  endfunction

  function automatic logic exp_busy(input int a);
    if (!rst_n || (ZERO && a == 0)) return 1'b0;
    if (write_live() && a == int'(inaddr) &&
        !(set_busy && set_addr == inaddr && !(ZERO && set_addr == 0))) return 1'b0;
    return ref_busy[a] != 0;
  endfunction

  function automatic logic [DEPTH-1:0] exp_vec();
    logic [DEPTH-1:0] v = '0;
    if (!rst_n) return '0;
    for (int i = 0; i < DEPTH; i++) v[i] = (ref_busy[i] != 0) && !(ZERO && i == 0);
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]  = 0;
      ref_busy[i] = 0;
    end
  endfunction

  // Advance one rising edge, applying the edge rules to the model, then leave 1 time unit of margin.
  task automatic tick();
    @(posedge ck);
    if (rst_n) begin
      if (we && !(ZERO && inaddr == 0)) begin
        ref_mem[inaddr]  = int'(din);
        ref_busy[inaddr] = 0;
      end
      if (set_busy && !(ZERO && set_addr == 0)) ref_busy[set_addr] = 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; set_busy = 1'b0; inaddr = '0; set_addr = '0; din = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b1; din = 8'hFF; inaddr = 2'd1;
    set_busy = 1'b1; set_addr = 2'd2; outaddr_a = 2'd1; outaddr_b = 2'd2;
    model_clear();
    tick(); tick();
    tests++;
    if (dout_a !== 8'h00 || dout_b !== 8'h00 || busy_a !== 1'b0 || busy_b !== 1'b0 || busy_vec !== 4'b0000) begin
      fails++;
      $display("FAIL reset_held: dout_a=%h dout_b=%h busy_a=%b busy_b=%b busy_vec=%b, required all zero",
               dout_a, dout_b, busy_a, busy_b, busy_vec);
    end
    idle_inputs();
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      outaddr_a = AW'(i); outaddr_b = AW'(DEPTH - 1 - i);
      #1;
      tests++;
      if (dout_a !== 8'h00 || dout_b !== 8'h00 || busy_vec !== 4'b0000) begin
        fails++;
        $display("FAIL reset_release[%0d]: dout_a=%h dout_b=%h busy_vec=%b, required 00 00 0000",
                 i, dout_a, dout_b, busy_vec);
      end
    end
  endtask

  task automatic test_fill_dual_read();
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; inaddr = AW'(i); din = WIDTH'(i + 1);
      tick();
    end
    idle_inputs();
    outaddr_a = 2'd1; outaddr_b = 2'd3;
    #1;
    tests++;
    if (dout_a !== 8'h02 || dout_b !== 8'h04) begin
      fails++;
      $display("FAIL dual_read: dout_a=%h dout_b=%h, required 02 04", dout_a, dout_b);
    end
    outaddr_a = 2'd3; outaddr_b = 2'd1;
    #1;
    tests++;
    if (dout_a !== 8'h04 || dout_b !== 8'h02) begin
      fails++;
      $display("FAIL dual_read_swap: dout_a=%h dout_b=%h, required 04 02", dout_a, dout_b);
    end
    outaddr_a = 2'd0; outaddr_b = 2'd2;
    #1;
    tests++;
    if (dout_a !== exp_dout(0) || dout_b !== 8'h03) begin
      fails++;
      $display("FAIL dual_read_02: dout_a=%h dout_b=%h, required %h 03", dout_a, dout_b, exp_dout(0));
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; inaddr = 2'd2; din = 8'hA5; outaddr_a = 2'd2; outaddr_b = 2'd2;
    #1;
    tests++;
    if (dout_a !== 8'hA5 || dout_b !== 8'hA5 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
      fails++;
      $display("FAIL bypass_pre_edge: dout_a=%h dout_b=%h busy_a=%b busy_b=%b, required A5 A5 0 0",
               dout_a, dout_b, busy_a, busy_b);
    end
    tick();
    idle_inputs();
    #1;
    tests++;
    if (dout_a !== 8'hA5 || dout_b !== 8'hA5) begin
      fails++;
      $display("FAIL bypass_post_edge: dout_a=%h dout_b=%h, required A5 A5", dout_a, dout_b);
    end
  endtask

  task automatic test_scoreboard();
    set_busy = 1'b1; set_addr = 2'd1; outaddr_a = 2'd1;
    tick();
    set_busy = 1'b0;
    #1;
    tests++;
    if (busy_vec !== 4'b0010 || busy_a !== 1'b1) begin
      fails++;
      $display("FAIL scoreboard_set: busy_vec=%b busy_a=%b, required 0010 1", busy_vec, busy_a);
    end
    we = 1'b1; inaddr = 2'd1; din = 8'h77;
    #1;
    tests++;
    if (busy_a !== 1'b0 || dout_a !== 8'h77 || busy_vec !== 4'b0010) begin
      fails++;
      $display("FAIL scoreboard_write_bypass: busy_a=%b dout_a=%h busy_vec=%b, required 0 77 0010",
               busy_a, dout_a, busy_vec);
    end
    tick();
    idle_inputs();
    #1;
    tests++;
    if (busy_vec !== 4'b0000 || dout_a !== 8'h77) begin
      fails++;
      $display("FAIL scoreboard_clear: busy_vec=%b dout_a=%h, required 0000 77", busy_vec, dout_a);
    end
  endtask

  task automatic test_set_and_write();
    we = 1'b1; inaddr = 2'd3; din = 8'h5A; set_busy = 1'b1; set_addr = 2'd3; outaddr_b = 2'd3;
    #1;
    tests++;
    if (dout_b !== 8'h5A || busy_b !== 1'b0) begin
      fails++;
      $display("FAIL set_write_pre_edge: dout_b=%h busy_b=%b, required 5A 0", dout_b, busy_b);
    end
    tick();
    // Second round on an already-busy register: busy must read its held 1, not the bypass 0.
    din = 8'hC3;
    #1;
    tests++;
    if (dout_b !== 8'hC3 || busy_b !== 1'b1) begin
      fails++;
      $display("FAIL set_write_hold_busy: dout_b=%h busy_b=%b, required C3 1", dout_b, busy_b);
    end
    we = 1'b0; din = 8'h00;
    #1;
    tests++;
    if (dout_b !== 8'h5A || busy_vec[3] !== 1'b1) begin
      fails++;
      $display("FAIL set_write_post_edge: dout_b=%h busy_vec=%b, required 5A busy_vec[3]=1", dout_b, busy_vec);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    set_busy = 1'b1; set_addr = 2'd1;
    tick();
    idle_inputs();
    outaddr_a = 2'd1; outaddr_b = 2'd3;
    #1;
    tests++;
    if (busy_vec !== 4'b1010 || dout_b !== 8'h5A) begin
      fails++;
      $display("FAIL async_setup: busy_vec=%b dout_b=%h, required 1010 5A", busy_vec, dout_b);
    end
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    tests++;
    if (dout_a !== 8'h00 || dout_b !== 8'h00 || busy_a !== 1'b0 || busy_b !== 1'b0 || busy_vec !== 4'b0000) begin
      fails++;
      $display("FAIL async_reset: dout_a=%h dout_b=%h busy_a=%b busy_b=%b busy_vec=%b, required all zero",
               dout_a, dout_b, busy_a, busy_b, busy_vec);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      we        = ($urandom_range(0, 2) != 0);
      inaddr    = AW'($urandom_range(0, DEPTH - 1));
      din       = WIDTH'($urandom);
      set_busy  = ($urandom_range(0, 3) == 0);
      set_addr  = ($urandom_range(0, 3) == 0) ? inaddr : AW'($urandom_range(0, DEPTH - 1));
      outaddr_a = ($urandom_range(0, 2) == 0) ? inaddr : AW'($urandom_range(0, DEPTH - 1));
      outaddr_b = ($urandom_range(0, 2) == 0) ? inaddr : AW'($urandom_range(0, DEPTH - 1));
      #1;
      tests++;
      if (dout_a !== exp_dout(int'(outaddr_a)) || busy_a !== exp_busy(int'(outaddr_a))) begin
        fails++;
        $display("FAIL random_a[%0d]: addr=%0d dout_a=%h busy_a=%b, required %h %b",
                 n, outaddr_a, dout_a, busy_a, exp_dout(int'(outaddr_a)), exp_busy(int'(outaddr_a)));
      end
      tests++;
      if (dout_b !== exp_dout(int'(outaddr_b)) || busy_b !== exp_busy(int'(outaddr_b))) begin
        fails++;
        $display("FAIL random_b[%0d]: addr=%0d dout_b=%h busy_b=%b, required %h %b",
                 n, outaddr_b, dout_b, busy_b, exp_dout(int'(outaddr_b)), exp_busy(int'(outaddr_b)));
      end
      tests++;
      if (busy_vec !== exp_vec()) begin
        fails++;
        $display("FAIL random_vec[%0d]: busy_vec=%b, required %b", n, busy_vec, exp_vec());
      end
      tick();
    end
    idle_inputs();
  endtask

`ifdef REGFILE_ZERO_REG_EN
  task automatic test_zero_reg();
    we = 1'b1; inaddr = 2'd0; din = 8'hFF; set_busy = 1'b1; set_addr = 2'd0; outaddr_a = 2'd0;
    #1;
    tests++;
    if (dout_a !== 8'h00 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL zero_reg_pre_edge: dout_a=%h busy_a=%b, required 00 0", dout_a, busy_a);
    end
    tick();
    idle_inputs();
    #1;
    tests++;
    if (dout_a !== 8'h00 || busy_vec[0] !== 1'b0) begin
      fails++;
      $display("FAIL zero_reg_post_edge: dout_a=%h busy_vec=%b, required 00 busy_vec[0]=0", dout_a, busy_vec);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    outaddr_a = '0; outaddr_b = '0;
    test_reset();
    test_fill_dual_read();
    test_bypass();
    test_scoreboard();
    test_set_and_write();
    test_async_reset();
    test_random();
`ifdef REGFILE_ZERO_REG_EN
    test_zero_reg();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
